// File: rtl/window_mean_filter_pkg.sv
// window_mean_filter_pkg: shared pixel-entry and 3x3 window types for the mean filter
package window_mean_filter_pkg;
  localparam int PIX_W = 8;
  typedef struct packed {
    logic             nod;
    logic [PIX_W-1:0] pix;
  } px_t;
  typedef px_t [2:0][2:0] win_t;
endpackage

// File: rtl/window_mean_filter_line_buffer.sv
// line_buffer: one image row of {nod,pix} entries, read-before-write at a single address
module line_buffer
  import window_mean_filter_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  px_t                      wdata,
  output px_t                      rdata
);
  px_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/window_mean_filter.sv
// window_mean_filter: 3x3 noise-aware mean filter replacing flagged centre pixels with the clean-neighbour mean
module window_mean_filter
  import window_mean_filter_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_nod,
  input  logic             in_sof,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_eol
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0]    col, cur_col;
  logic [RW-1:0]    row, cur_row;
  logic             last_col;
  px_t              in_px, lb0_rd, lb1_rd;
  win_t             win;
  logic             win_v, win_eol;
  logic [10:0]      sum;
  logic [3:0]       k;
  logic [PIX_W-1:0] res;
  assign in_px    = {in_nod, in_pix};
  assign cur_col  = in_sof ? '0 : col;
  assign cur_row  = in_sof ? '0 : row;
  assign last_col = cur_col == CW'(IMG_W - 1);
  line_buffer #(.DEPTH(IMG_W)) u_lb0 (.clk(clk), .we(in_valid), .addr(cur_col), .wdata(in_px),  .rdata(lb0_rd));
  line_buffer #(.DEPTH(IMG_W)) u_lb1 (.clk(clk), .we(in_valid), .addr(cur_col), .wdata(lb0_rd), .rdata(lb1_rd));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      col <= last_col ? '0 : cur_col + CW'(1);
      row <= !last_col ? cur_row : (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win     <= '0;
      win_v   <= 1'b0;
      win_eol <= 1'b0;
    end else begin
      win_v   <= in_valid && cur_row >= RW'(2) && cur_col >= CW'(2);
      win_eol <= last_col;
      if (in_valid) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= in_px;
      end
    end
  end
  // a noisy centre with no clean neighbour falls back to the previous output held in out_pix
  always_comb begin
    sum = '0;
    k   = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (!(r == 1 && c == 1) && !win[r][c].nod) begin
          sum = sum + 11'(win[r][c].pix);
          k   = k + 4'd1;
        end
    res = !win[1][1].nod ? win[1][1].pix : (k != 4'd0) ? PIX_W'(sum / 11'(k)) : out_pix;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_eol   <= 1'b0;
    end else begin
      out_valid <= win_v;
      out_eol   <= win_v && win_eol;
      if (win_v) out_pix <= res;
    end
  end
endmodule
